cnn_layer_accel_sys_mem_rd_arb: RTL
===================================

CNN_LAYER_ACCEL_SYS_MEM_RD_ARB -- requirements
Module: cnn_layer_accel_sys_mem_rd_arb

Interface
REQ-001 SHALL have parameter C_NUM_RD_ID, default 4, meaning number of FAS read requesters (matches `MAX_FAS_RD_ID).
REQ-002 SHALL have parameter C_ADDR_WTH, default 32, meaning per-requester read address width.
REQ-003 SHALL have parameter C_LEN_WTH, default 16, meaning per-requester read length width, in data beats.
REQ-004 Clocking is decided: one clock, clk_intf; reset is synchronous and active-low, port rst.
REQ-005 clk_intf  input  1  interface clock; all logic on its rising edge.
REQ-006 rst  input  1  synchronous active-low reset.
REQ-007 sys_mem_read_req  input  C_NUM_RD_ID  per-requester level request, held until req_ack.
REQ-008 sys_mem_read_addr  input  C_NUM_RD_ID*C_ADDR_WTH  packed addresses; slice i belongs to requester i.
REQ-009 sys_mem_read_len  input  C_NUM_RD_ID*C_LEN_WTH  packed lengths; slice i belongs to requester i.
REQ-010 sys_mem_read_req_ack  output  C_NUM_RD_ID  one-cycle grant-accepted pulse.
REQ-011 sys_mem_read_in_prog  output  C_NUM_RD_ID  high while the granted transfer is moving data.
REQ-012 sys_mem_read_cmpl  output  C_NUM_RD_ID  one-cycle completion pulse.
REQ-013 axi_rd_req / axi_rd_addr / axi_rd_len  output  1 / C_ADDR_WTH / C_LEN_WTH  command to AXI read master.
REQ-014 axi_rd_req_ack  input  1  AXI master accepted the command.
REQ-015 axi_rd_data_vld  input  1  one returned data beat this cycle.
REQ-016 axi_rd_id  output  clog2(C_NUM_RD_ID)  index of the current owner, for read-data routing.

Function
REQ-017 FSM states SHALL be IDLE, CMD, XFER, DONE.
REQ-018 IDLE: if any req bit is high, select the winner, register its index, addr and len, and enter CMD the next cycle.
REQ-019 CMD: axi_rd_req=1 with registered addr/len, held until axi_rd_req_ack.
REQ-020 CMD exit: on axi_rd_req_ack, pulse req_ack[id] for exactly 1 cycle.
REQ-021 CMD exit: go to XFER, or to DONE directly if len==0.
REQ-022 XFER: in_prog[id]=1; a C_LEN_WTH-bit beat counter increments on each axi_rd_data_vld.
REQ-023 XFER exit: when the counter reaches len-1 with data_vld, go to DONE; in_prog drops that same cycle.
REQ-024 DONE: pulse cmpl[id] for 1 cycle, then return to IDLE.
REQ-025 Re-arbitration latency SHALL be 1 cycle minimum: the cycle after DONE, IDLE may grant again.
REQ-026 Requests are sampled only in IDLE; req changes in other states are ignored.
REQ-027 A requester that drops req before the grant is not served.
REQ-028 axi_rd_data_vld outside XFER SHALL be ignored; the counter does not move.
REQ-029 Arbitration is round-robin by default: search starts at last_grant+1 modulo C_NUM_RD_ID.
REQ-030 last_grant updates on each grant.
REQ-031 axi_rd_id SHALL equal the registered owner index in CMD, XFER and DONE; it is 0 in IDLE.
REQ-032 At most one bit of req_ack, in_prog or cmpl SHALL be high in any cycle.

Reset
REQ-033 While rst=0 at a clk_intf edge, the FSM SHALL go to IDLE, with last_grant = C_NUM_RD_ID-1 so requester 0 wins first.
REQ-034 Reset SHALL clear the counter to 0.
REQ-035 Reset SHALL drive all outputs to 0.
REQ-036 Reset mid-transfer SHALL abandon the transfer: no cmpl pulse, in_prog low the next cycle.

Configuration
REQ-037 Macro SYS_MEM_RD_ARB_FIXED_PRIO_EN SHALL select the arbitration mode at compile time.
REQ-038 With the macro defined: fixed priority, lowest set req index wins, last_grant unused.
REQ-039 Without the macro: round-robin per REQ-029 and REQ-030.

Verification
REQ-040 Single request: req=4'b0010, addr1=0x1000, len1=3, ack after 2 cycles. Required: axi_rd_addr=0x1000, axi_rd_len=3, req_ack[1] one pulse, in_prog[1] for the 3 beats, cmpl[1] pulse, axi_rd_id=1.
REQ-041 Contention, round-robin: req=4'b1111 held; each len=1. Required: grant order 0,1,2,3,0.
REQ-042 Contention, fixed priority (macro defined): same stimulus as REQ-041. Required: grant order 0,0,0,...
REQ-043 len=0: req0 with len=0. Required: CMD -> DONE, cmpl[0] one cycle after req_ack[0], in_prog never high.
REQ-044 Stray beats: axi_rd_data_vld pulses in IDLE and CMD, then len=2. Required: completion only after exactly 2 beats seen in XFER.
REQ-045 Reset mid-XFER: rst=0 after 1 of 4 beats. Required: all outputs 0 next cycle, no cmpl; afterwards req=4'b0100 is granted to requester 2 normally.

Source files
------------

// File: rtl/cnn_layer_accel_sys_mem_rd_arb_if.sv
// Read-arbiter bundle: per-requester request/address/length/status plus the AXI read-master command side.
// Carries no state and adds no latency.
// Backpressure is handled by the level requests and the axi_rd_req/axi_rd_req_ack command handshake.
interface cnn_layer_accel_sys_mem_rd_arb_if #(
    parameter int C_NUM_RD_ID = 4,
    parameter int C_ADDR_WTH  = 32,
    parameter int C_LEN_WTH   = 16
);
    localparam int ID_W = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;

    logic [C_NUM_RD_ID-1:0]            sys_mem_read_req;
    logic [C_NUM_RD_ID*C_ADDR_WTH-1:0] sys_mem_read_addr;
    logic [C_NUM_RD_ID*C_LEN_WTH-1:0]  sys_mem_read_len;
    logic [C_NUM_RD_ID-1:0]            sys_mem_read_req_ack;
    logic [C_NUM_RD_ID-1:0]            sys_mem_read_in_prog;
    logic [C_NUM_RD_ID-1:0]            sys_mem_read_cmpl;
    logic                              axi_rd_req;
    logic [C_ADDR_WTH-1:0]             axi_rd_addr;
    logic [C_LEN_WTH-1:0]              axi_rd_len;
    logic                              axi_rd_req_ack;
    logic                              axi_rd_data_vld;
    logic [ID_W-1:0]                   axi_rd_id;

    // Requesters and AXI master side (the environment around the arbiter).
    modport master (
        output sys_mem_read_req, sys_mem_read_addr, sys_mem_read_len,
        output axi_rd_req_ack, axi_rd_data_vld,
        input  sys_mem_read_req_ack, sys_mem_read_in_prog, sys_mem_read_cmpl,
        input  axi_rd_req, axi_rd_addr, axi_rd_len, axi_rd_id
    );

    // The arbiter itself.
    modport slave (
        input  sys_mem_read_req, sys_mem_read_addr, sys_mem_read_len,
        input  axi_rd_req_ack, axi_rd_data_vld,
        output sys_mem_read_req_ack, sys_mem_read_in_prog, sys_mem_read_cmpl,
        output axi_rd_req, axi_rd_addr, axi_rd_len, axi_rd_id
    );
endinterface

// File: rtl/cnn_layer_accel_sys_mem_rd_arb.sv
// Arbitrates C_NUM_RD_ID read requesters onto one AXI read master; round-robin, or fixed priority with SYS_MEM_RD_ARB_FIXED_PRIO_EN.
// Latency: grant registered one cycle after a request is seen in IDLE; re-arbitration one cycle after DONE.
// Backpressure: the command is held until axi_rd_req_ack; requests are only sampled in IDLE.
module cnn_layer_accel_sys_mem_rd_arb #(
    parameter int C_NUM_RD_ID = 4,
    parameter int C_ADDR_WTH  = 32,
    parameter int C_LEN_WTH   = 16
) (
    input logic                             clk_intf,
    input logic                             rst,
    cnn_layer_accel_sys_mem_rd_arb_if.slave bus
);
    localparam int ID_W = (C_NUM_RD_ID > 1) ? $clog2(C_NUM_RD_ID) : 1;

    typedef enum logic [1:0] {IDLE, CMD, XFER, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ID_W-1:0]       owner;
    logic [C_ADDR_WTH-1:0] addr_r;
    logic [C_LEN_WTH-1:0]  len_r;
    logic [C_LEN_WTH-1:0]  cnt;
    logic                  any_req;
    logic [ID_W-1:0]       win;
    logic                  grant;

`ifndef SYS_MEM_RD_ARB_FIXED_PRIO_EN
    logic [ID_W-1:0]       last_grant;
`endif

    assign grant = (state == IDLE) && any_req;

    // Pick the winning requester from the current request vector.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
`ifdef SYS_MEM_RD_ARB_FIXED_PRIO_EN
        // Scan downwards so the lowest set index is the last one written.
        for (int k = C_NUM_RD_ID - 1; k >= 0; k--) begin
            if (bus.sys_mem_read_req[ID_W'(k)]) begin
                any_req = 1'b1;
                win     = ID_W'(k);
            end
        end
`else
        // Search starts just after the previous winner, wrapping at C_NUM_RD_ID.
        for (int k = 0; k < C_NUM_RD_ID; k++) begin
            int idx;
            idx = int'(last_grant) + 1 + k;
            if (idx >= C_NUM_RD_ID) idx = idx - C_NUM_RD_ID;
            if (idx >= C_NUM_RD_ID) idx = idx - C_NUM_RD_ID;
            if (!any_req && bus.sys_mem_read_req[ID_W'(idx)]) begin
                any_req = 1'b1;
                win     = ID_W'(idx);
            end
        end
`endif
    end

    // State register.
    always_ff @(posedge clk_intf) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

`ifndef SYS_MEM_RD_ARB_FIXED_PRIO_EN
    // Remember the last winner; reset value makes requester 0 win first.
    always_ff @(posedge clk_intf) begin
        if (!rst)       last_grant <= ID_W'(C_NUM_RD_ID - 1);
        else if (grant) last_grant <= win;
    end
`endif

    // Capture the winner's command on grant and count beats during XFER only.
    always_ff @(posedge clk_intf) begin
        if (!rst) begin
            owner  <= '0;
            addr_r <= '0;
            len_r  <= '0;
            cnt    <= '0;
        end else if (grant) begin
            owner  <= win;
            addr_r <= C_ADDR_WTH'(bus.sys_mem_read_addr >> (int'(win) * C_ADDR_WTH));
            len_r  <= C_LEN_WTH'(bus.sys_mem_read_len >> (int'(win) * C_LEN_WTH));
            cnt    <= '0;
        end else if (state == XFER && bus.axi_rd_data_vld) begin
            cnt <= cnt + 1'b1;
        end
    end

    // Next-state logic and one-hot status outputs keyed by the registered owner.
    always_comb begin
        state_nxt                = state;
        bus.axi_rd_req           = 1'b0;
        bus.axi_rd_addr          = '0;
        bus.axi_rd_len           = '0;
        bus.axi_rd_id            = '0;
        bus.sys_mem_read_req_ack = '0;
        bus.sys_mem_read_in_prog = '0;
        bus.sys_mem_read_cmpl    = '0;
        case (state)
            IDLE: begin
                if (any_req) state_nxt = CMD;
            end
            CMD: begin
                bus.axi_rd_req  = 1'b1;
                bus.axi_rd_addr = addr_r;
                bus.axi_rd_len  = len_r;
                bus.axi_rd_id   = owner;
                if (bus.axi_rd_req_ack) begin
                    bus.sys_mem_read_req_ack[owner] = 1'b1;
                    state_nxt = (len_r == '0) ? DONE : XFER;
                end
            end
            XFER: begin
                bus.sys_mem_read_in_prog[owner] = 1'b1;
                bus.axi_rd_id = owner;
                if (bus.axi_rd_data_vld && cnt == len_r - 1'b1) state_nxt = DONE;
            end
            DONE: begin
                bus.sys_mem_read_cmpl[owner] = 1'b1;
                bus.axi_rd_id = owner;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
endmodule
